mem_arbiter: RTL and testbench

Shares one unified, variable-latency memory port between the CPU's instruction-fetch path and its load/store data path. It sits between the 16-bit CPU and the single-ported memory.
- Each requester issues a held request and receives a one-cycle acknowledge with read data.
- Contention is resolved round-robin.
- A watchdog aborts transactions the memory never completes.
- The CPU stalls on the missing acknowledge.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one variable-latency memory port between
// instruction fetch and load/store, with a watchdog that aborts stuck transactions.
module mem_arbiter #(
    parameter int n       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic [n-1:0] if_rdata,
    output logic         if_ack,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic [n-1:0] d_rdata,
    output logic         d_ack,
    output logic         err,
    output logic         m_req,
    output logic         m_we,
    output logic [n-1:0] m_addr,
    output logic [n-1:0] m_wdata,
    input  logic [n-1:0] m_rdata,
    input  logic         m_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t       state_q, state_d;
    logic [n-1:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [n-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic         m_we_q, m_we_d, if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic         err_q, err_d, last_d_q, last_d_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         if_elig, d_elig, grant_i, grant_d;
    logic [n-1:0] rd;

    // A requester whose ack is showing this cycle waits one more cycle before re-arbitration
    assign if_elig = if_req && !if_ack_q;
    assign d_elig  = d_req && !d_ack_q;
    assign grant_i = if_elig && (!d_elig || last_d_q);
    assign grant_d = d_elig && !grant_i;
    assign rd      = m_ready ? m_rdata : '0;

    always_comb begin
        state_d    = state_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_we_d     = m_we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        last_d_d   = last_d_q;
        cnt_d      = cnt_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        if (state_q == IDLE) begin
            if (grant_i || grant_d) begin
                state_d   = grant_i ? BUSY_I : BUSY_D;
                m_addr_d  = grant_i ? if_addr : d_addr;
                m_wdata_d = grant_i ? '0 : d_wdata;
                m_we_d    = grant_d && d_we;
                last_d_d  = grant_d;
                cnt_d     = '0;
            end
        end else if (m_ready || cnt_q == TMO) begin
            // m_ready takes priority over the watchdog when both land together
            state_d    = IDLE;
            if_ack_d   = state_q == BUSY_I;
            d_ack_d    = state_q == BUSY_D;
            err_d      = !m_ready;
            if_rdata_d = state_q == BUSY_I ? rd : if_rdata_q;
            d_rdata_d  = state_q == BUSY_D ? rd : d_rdata_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_we_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            last_d_q   <= 1'b1;
            cnt_q      <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_we_q     <= m_we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            last_d_q   <= last_d_d;
            cnt_q      <= cnt_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
        end
    end

    assign m_req    = state_q != IDLE;
    assign m_we     = m_we_q && state_q == BUSY_D;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, corner-case sequences and random traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        if_req = 0, d_req = 0, d_we = 0, m_ready = 0;
    logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, d_ack, err, m_req, m_we;

    int n_cmp = 0, n_bad = 0;

    mem_arbiter #(.n(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Transaction-level model: current owner of the memory port and what it carries
    int          mo_owner, mo_wait;
    bit          mo_last_d, mo_we, mo_err;
    bit   [1:0]  mo_ack;
    logic [15:0] mo_addr, mo_wdata;
    logic [15:0] mo_rdata [2];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mo_owner = -1; mo_wait = 0; mo_last_d = 1; mo_we = 0; mo_err = 0; mo_ack = 0;
        mo_addr = 0; mo_wdata = 0; mo_rdata[0] = 0; mo_rdata[1] = 0;
    endtask

    task automatic model_step();
        bit [1:0] nack;
        bit nerr, ei, ed;
        int pick;
        nack = 0; nerr = 0; pick = -1;
        if (mo_owner >= 0) begin
            if (m_ready) begin
                nack[mo_owner] = 1; mo_rdata[mo_owner] = m_rdata; mo_owner = -1;
            end else if (mo_wait == TO) begin
                nack[mo_owner] = 1; nerr = 1; mo_rdata[mo_owner] = 0; mo_owner = -1;
            end else mo_wait++;
        end else begin
            ei = if_req && !mo_ack[0];
            ed = d_req && !mo_ack[1];
            if (ei && ed) pick = mo_last_d ? 0 : 1;
            else if (ei) pick = 0;
            else if (ed) pick = 1;
            if (pick == 0) begin mo_addr = if_addr; mo_we = 0; mo_wdata = 0; end
            if (pick == 1) begin mo_addr = d_addr; mo_we = d_we; mo_wdata = d_wdata; end
            if (pick >= 0) begin mo_owner = pick; mo_wait = 0; mo_last_d = pick == 1; end
        end
        mo_ack = nack;
        mo_err = nerr;
    endtask

    task automatic check_model();
        logic [68:0] e, a;
        bit mr;
        mr = mo_owner >= 0;
        e = {mr, mr && mo_owner == 1 && mo_we, mr ? mo_addr : 16'h0, mr ? mo_wdata : 16'h0,
             mo_ack[0], mo_ack[1], mo_err,
             mo_ack[0] ? mo_rdata[0] : 16'h0, mo_ack[1] ? mo_rdata[1] : 16'h0};
        a = {m_req, m_we, mr ? m_addr : 16'h0, mr ? m_wdata : 16'h0, if_ack, d_ack, err,
             mo_ack[0] ? if_rdata : 16'h0, mo_ack[1] ? d_rdata : 16'h0};
        chk("model", 96'(a), 96'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic zero_inputs();
        if_req = 0; d_req = 0; d_we = 0; m_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, 96'({m_req, m_we, m_addr, m_wdata, if_ack, d_ack, err, if_rdata, d_rdata}), 96'(0));
    endtask

    task automatic do_reset();
        reset = 1;
        zero_inputs();
        model_reset();
        #1;
        check_reset_vals("reset_vals");
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    typedef struct {
        logic ir; logic [15:0] ia; logic dr, dw; logic [15:0] da, dd; logic mr; logic [15:0] md;
        logic e_mreq, e_mwe; logic [15:0] e_ma, e_mw; logic e_ia, e_da, e_err, chk; logic [15:0] e_rd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int cnt, nxt;
        logic [68:0] va, ve;
        tbl[0]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA5A5};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[10] = tbl[3];

        do_reset();
        for (int r = 0; r < 11; r++) begin
            if_req = tbl[r].ir; if_addr = tbl[r].ia; d_req = tbl[r].dr; d_we = tbl[r].dw;
            d_addr = tbl[r].da; d_wdata = tbl[r].dd; m_ready = tbl[r].mr; m_rdata = tbl[r].md;
            ve = {tbl[r].e_mreq, tbl[r].e_mwe, tbl[r].e_mreq ? tbl[r].e_ma : 16'h0,
                  tbl[r].e_mreq ? tbl[r].e_mw : 16'h0, tbl[r].e_ia, tbl[r].e_da, tbl[r].e_err,
                  tbl[r].chk ? tbl[r].e_rd : 16'h0, 16'h0};
            va = {m_req, m_we, m_req ? m_addr : 16'h0, m_req ? m_wdata : 16'h0, if_ack, d_ack, err,
                  tbl[r].chk ? (if_ack ? if_rdata : d_rdata) : 16'h0, 16'h0};
            chk($sformatf("vec%0d", r), 96'(va), 96'(ve));
            tick();
        end

        // Contention: both held, memory always ready
        do_reset();
        if_req = 1; if_addr = 16'h1000; d_req = 1; d_we = 0; d_addr = 16'h2000; m_ready = 1; m_rdata = 16'h5555;
        cnt = 0; nxt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("two_acks", 96'(if_ack && d_ack), 96'(0));
            if (if_ack || d_ack) begin
                chk("rr_order", 96'({if_ack, d_ack}), 96'(nxt == 0 ? 2'b10 : 2'b01));
                nxt ^= 1;
                cnt++;
            end
        end
        chk("rr_count", 96'(cnt), 96'(6));

        // Timeout: load never answered
        do_reset();
        d_req = 1; d_we = 0; d_addr = 16'h0200;
        tick();
        cnt = 0;
        for (int i = 0; i < 20 && !d_ack; i++) begin
            if (m_req) cnt++;
            if (i == 4) d_req = 0;
            tick();
        end
        chk("tmo_mreq_cycles", 96'(cnt), 96'(TO + 1));
        chk("tmo_ack", 96'({d_ack, err, d_rdata, m_req}), 96'({1'b1, 1'b1, 16'h0, 1'b0}));
        d_req = 0;
        tick();
        chk("tmo_idle", 96'({m_req, d_ack, err}), 96'(0));

        // m_ready on the very cycle the watchdog would fire
        do_reset();
        d_req = 1; d_we = 0; d_addr = 16'h0300;
        tick();
        for (int i = 0; i < TO; i++) tick();
        m_ready = 1; m_rdata = 16'hBEEF; d_req = 0;
        tick();
        chk("tie_ack", 96'({d_ack, err, d_rdata}), 96'({1'b1, 1'b0, 16'hBEEF}));
        m_ready = 0;

        // Asynchronous reset in the middle of a data transaction
        do_reset();
        d_req = 1; d_we = 1; d_addr = 16'h0400; d_wdata = 16'h7777;
        tick();
        chk("mid_busy", 96'({m_req, m_we}), 96'(2'b11));
        #2 reset = 1;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        chk("no_ack_in_reset", 96'({d_ack, m_req}), 96'(0));
        @(negedge clk);
        reset = 0;
        if_req = 1; if_addr = 16'h0500;
        tick();
        chk("post_reset_tie", 96'({m_req, m_we, m_addr, d_ack}), 96'({1'b1, 1'b0, 16'h0500, 1'b0}));
        if_req = 0; d_req = 0;
        m_ready = 1;
        tick();
        m_ready = 0;
        tick();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1; if_addr = 16'($urandom); end
            end else if (mo_ack[0]) begin
                if_req = 1'($urandom_range(1)); if_addr = 16'($urandom);
            end
            if (!d_req) begin
                if ($urandom_range(2) == 0) begin
                    d_req = 1; d_we = 1'($urandom_range(1)); d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end else if (mo_ack[1]) begin
                d_req = 1'($urandom_range(1)); d_we = 1'($urandom_range(1));
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            m_ready = $urandom_range(4) < 2;
            m_rdata = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
